iob_cfg_loader: RTL

//  Serial configuration loader that sits directly upstream of the IO block array.

---
 rtl/iob_cfg_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/iob_cfg_loader.sv
// Serial IO-block configuration loader: sync hunt, 3-bit-per-IOB payload capture, check, atomic commit.
// Build option: define IOB_CFG_CRC_EN for an 8-bit CRC-8 check field instead of 1-bit even parity.
module iob_cfg_loader #(
  parameter int unsigned NUM_IOB   = 4,
  parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
  input  logic                 IOCLK,
  input  logic                 RSTN,
  input  logic                 START,
  input  logic                 DIN,
  input  logic                 DVALID,
  output logic [2*NUM_IOB-1:0] TSMUX_CFG,
  output logic [NUM_IOB-1:0]   DORREG_CFG,
  output logic                 BUSY,
  output logic                 CFG_DONE,
  output logic                 CFG_ERR
);

  localparam int unsigned PAY_BITS = 3 * NUM_IOB;
`ifdef IOB_CFG_CRC_EN
  localparam int unsigned CHK_BITS = 8;
`else
  localparam int unsigned CHK_BITS = 1;
`endif
  localparam int unsigned CNT_W = $clog2(PAY_BITS + CHK_BITS);

  // EVAL is the single cycle between the last check bit and the registered verdict.
  typedef enum logic [2:0] {IDLE, HUNT, PAYLOAD, CHECK, EVAL} state_t;

  state_t                 state, state_n;
  logic [7:0]             window, window_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [PAY_BITS-1:0]    shadow, shadow_n;
  logic [CHK_BITS-1:0]    acc, acc_n;
  logic [2*NUM_IOB-1:0]   tsmux_n, ts_sh;
  logic [NUM_IOB-1:0]     dorreg_n, dr_sh;
  logic                   busy_n, done_n, err_n;
  logic [7:0]             win_shift;
  logic                   pass;
`ifdef IOB_CFG_CRC_EN
  logic [7:0]             rx, rx_n;
  logic                   crc_fb;
`endif

  // Shadow holds the first payload bit at its MSB; unpack into per-IOB fields.
  for (genvar g = 0; g < NUM_IOB; g++) begin : g_map
    assign ts_sh[2*g+1] = shadow[PAY_BITS-1-3*g];
    assign ts_sh[2*g]   = shadow[PAY_BITS-2-3*g];
    assign dr_sh[g]     = shadow[PAY_BITS-3-3*g];
  end

  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      window     <= '0;
      cnt        <= '0;
      shadow     <= '0;
      acc        <= '0;
      TSMUX_CFG  <= '0;
      DORREG_CFG <= '0;
      BUSY       <= 1'b0;
      CFG_DONE   <= 1'b0;
      CFG_ERR    <= 1'b0;
`ifdef IOB_CFG_CRC_EN
      rx         <= '0;
`endif
    end else begin
      state      <= state_n;
      window     <= window_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      acc        <= acc_n;
      TSMUX_CFG  <= tsmux_n;
      DORREG_CFG <= dorreg_n;
      BUSY       <= busy_n;
      CFG_DONE   <= done_n;
      CFG_ERR    <= err_n;
`ifdef IOB_CFG_CRC_EN
      rx         <= rx_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    window_n  = window;
    cnt_n     = cnt;
    shadow_n  = shadow;
    acc_n     = acc;
    tsmux_n   = TSMUX_CFG;
    dorreg_n  = DORREG_CFG;
    done_n    = CFG_DONE;
    err_n     = CFG_ERR;
    win_shift = {window[6:0], DIN};
`ifdef IOB_CFG_CRC_EN
    rx_n      = rx;
    crc_fb    = acc[7] ^ DIN;
    pass      = (rx == acc);
`else
    pass      = (acc == '0);
`endif

    case (state)
      IDLE: ;
      HUNT: begin
        if (DVALID) begin
          window_n = win_shift;
          if (win_shift == SYNC_WORD) begin
            state_n = PAYLOAD;
            cnt_n   = '0;
          end
        end
      end
      PAYLOAD: begin
        if (DVALID) begin
          shadow_n = {shadow[PAY_BITS-2:0], DIN};
`ifdef IOB_CFG_CRC_EN
          acc_n    = {acc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`else
          acc_n    = acc ^ DIN;
`endif
          cnt_n    = cnt + CNT_W'(1);
          if (cnt == CNT_W'(PAY_BITS - 1)) begin
            state_n = CHECK;
            cnt_n   = '0;
          end
        end
      end
      CHECK: begin
        if (DVALID) begin
`ifdef IOB_CFG_CRC_EN
          rx_n  = {rx[6:0], DIN};
`else
          acc_n = acc ^ DIN;
`endif
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(CHK_BITS - 1)) begin
            state_n = EVAL;
            cnt_n   = '0;
          end
        end
      end
      EVAL: begin
        if (pass) begin
          tsmux_n  = ts_sh;
          dorreg_n = dr_sh;
          done_n   = 1'b1;
          err_n    = 1'b0;
        end else begin
          done_n   = 1'b0;
          err_n    = 1'b1;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Re-arm wins over everything except a commit already due this edge.
    if (START) begin
      state_n  = HUNT;
      window_n = '0;
      cnt_n    = '0;
      shadow_n = '0;
      acc_n    = '0;
      done_n   = 1'b0;
      err_n    = 1'b0;
`ifdef IOB_CFG_CRC_EN
      rx_n     = '0;
`endif
    end

    busy_n = (state_n != IDLE);
  end

endmodule
